// File: rtl/ev_charge_scheduler.sv
// ev_charge_scheduler: round-robin time-sharing of one charger among NUM_BAYS bays
// Ports:
//   Clock    - system clock, rising edge
//   Reset    - asynchronous active-low reset
//   Request  - per-bay charge request (bay occupied)
//   Full     - per-bay counter-at-max flag
//   Increase - one-hot single-cycle pulse to the owning bay's charge counter
//   Grant    - one-hot current owner, 0 when none
//   GrantIdx - index of owner, 0 when none
//   Busy     - high while arbitrating or charging
// Optional: define SCHED_PRIORITY_BAY0_EN to let bay 0 win every arbitration it is eligible for.
module ev_charge_scheduler #(
   parameter int NUM_BAYS  = 4,
   parameter int PULSE_DIV = 4,
   parameter int SLICE     = 2
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic [NUM_BAYS-1:0]         Request,
   input  logic [NUM_BAYS-1:0]         Full,
   output logic [NUM_BAYS-1:0]         Increase,
   output logic [NUM_BAYS-1:0]         Grant,
   output logic [$clog2(NUM_BAYS)-1:0] GrantIdx,
   output logic                        Busy
);
   localparam int IW = $clog2(NUM_BAYS);
   localparam int DW = $clog2(PULSE_DIV + 1);
   localparam int PW = $clog2(SLICE + 1);
   typedef enum logic [1:0] {IDLE, ARB, CHARGE} state_t;
   state_t          state;
   logic [DW-1:0]   div_cnt;
   logic [PW-1:0]   pulse_cnt;
   logic [IW-1:0]   last_ptr, win;
   logic            found, pulse;
   logic [NUM_BAYS-1:0] eligible;
   assign eligible = Request & ~Full;
   // An owner that loses eligibility gets no pulse in that cycle, even on a divider boundary.
   assign pulse    = state == CHARGE && div_cnt == '0 && eligible[GrantIdx];
   assign Increase = pulse ? Grant : '0;
   assign Busy     = state != IDLE;
   // Scan downwards so the bay closest after last_ptr is the final (winning) assignment.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = NUM_BAYS; k >= 1; k--) begin
         if (eligible[IW'((int'(last_ptr) + k) % NUM_BAYS)]) begin
            found = 1'b1;
            win   = IW'((int'(last_ptr) + k) % NUM_BAYS);
         end
      end
`ifdef SCHED_PRIORITY_BAY0_EN
      if (eligible[0]) begin
         found = 1'b1;
         win   = '0;
      end
`else
`endif
   end
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         Grant     <= '0;
         GrantIdx  <= '0;
         div_cnt   <= '0;
         pulse_cnt <= '0;
         last_ptr  <= IW'(NUM_BAYS - 1);
      end else begin
         case (state)
            IDLE: state <= |eligible ? ARB : IDLE;
            ARB: begin
               if (found) begin
                  state     <= CHARGE;
                  Grant     <= NUM_BAYS'(1) << win;
                  GrantIdx  <= win;
                  last_ptr  <= win;
                  div_cnt   <= DW'(PULSE_DIV - 1);
                  pulse_cnt <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            CHARGE: begin
               if (!eligible[GrantIdx] || (pulse && pulse_cnt == PW'(SLICE - 1))) begin
                  state    <= ARB;
                  Grant    <= '0;
                  GrantIdx <= '0;
               end else if (pulse) begin
                  pulse_cnt <= pulse_cnt + 1'b1;
                  div_cnt   <= DW'(PULSE_DIV - 1);
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ev_charge_scheduler.sv
// tb_ev_charge_scheduler: randomized and directed bench for ev_charge_scheduler against a behavioural model
module tb_ev_charge_scheduler;
   localparam int N  = 4;
   localparam int PD = 4;
   localparam int SL = 2;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] full = '0;
   logic [N-1:0] inc, grant;
   logic [1:0]   gidx;
   logic         busy;
   int passed = 0;
   int total  = 0;
   // model: owner index (-1 none), arbitration-pending flag, cycles since grant, pulses delivered
   int m_owner = -1;
   int m_last  = N - 1;
   int m_t     = 0;
   int m_pulses = 0;
   bit m_arb   = 1'b0;
   ev_charge_scheduler #(.NUM_BAYS(N), .PULSE_DIV(PD), .SLICE(SL)) dut (
      .Clock(clk), .Reset(rst_n), .Request(req), .Full(full),
      .Increase(inc), .Grant(grant), .GrantIdx(gidx), .Busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask
   function automatic int pick(input logic [N-1:0] e, input int last);
`ifdef SCHED_PRIORITY_BAY0_EN
      if (e[0]) return 0;
`else
`endif
      for (int k = 1; k <= N; k++)
         if (e[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction
   always @(posedge clk) begin
      logic [N-1:0] e;
      int w;
      e = req & ~full;
      if (!rst_n) begin
         m_owner = -1; m_last = N - 1; m_t = 0; m_pulses = 0; m_arb = 1'b0;
      end else if (m_owner >= 0) begin
         if (!e[m_owner]) begin
            m_owner = -1; m_arb = 1'b1;
         end else if (m_t % PD == 0) begin
            m_pulses++;
            if (m_pulses == SL) begin m_owner = -1; m_arb = 1'b1; end
            else m_t++;
         end else m_t++;
      end else if (m_arb) begin
         w = pick(e, m_last);
         m_arb = 1'b0;
         if (w >= 0) begin m_owner = w; m_last = w; m_t = 1; m_pulses = 0; end
      end else if (|e) m_arb = 1'b1;
   end
   always @(negedge clk) begin
      logic [N-1:0] e;
      int eg, ei, ebusy, eidx;
      e = req & ~full;
      eg = 0; ei = 0; ebusy = 0; eidx = 0;
      if (rst_n) begin
         eg    = m_owner >= 0 ? (1 << m_owner) : 0;
         eidx  = m_owner >= 0 ? m_owner : 0;
         ei    = (m_owner >= 0 && e[m_owner] && m_t % PD == 0) ? eg : 0;
         ebusy = (m_arb || m_owner >= 0) ? 1 : 0;
      end
      check("model_grant", int'(grant), eg);
      check("model_idx", int'(gidx), eidx);
      check("model_inc", int'(inc), ei);
      check("model_busy", int'(busy), ebusy);
   end
   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0; req = '0; full = '0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask
   initial begin
      int order[8];
      int pulses[8];
      int ep, bad, waited;
      logic [N-1:0] prev;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("idle_grant", int'(grant), 0);
         check("idle_inc", int'(inc), 0);
         check("idle_busy", int'(busy), 0);
      end
      // single requester: owner from edge 1 to 8, pulses at 4 and 8, ARB at 9, re-grant at 10
      @(posedge clk); #1 req = 4'b0001;
      for (int n = 0; n <= 10; n++) begin
         @(posedge clk); @(negedge clk);
         check("solo_grant", int'(grant), ((n >= 1 && n <= 8) || n == 10) ? 1 : 0);
         check("solo_inc", int'(inc), (n == 4 || n == 8) ? 1 : 0);
      end
      do_reset();
      req = 4'b1111;
      ep = -1; prev = '0;
      for (int i = 0; i < 8; i++) begin order[i] = -1; pulses[i] = 0; end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (grant != 0 && prev == 0 && ep < 7) begin ep++; order[ep] = int'(gidx); end
         if (inc != 0 && ep >= 0) pulses[ep]++;
         prev = grant;
      end
      for (int i = 0; i < 5; i++) begin
`ifdef SCHED_PRIORITY_BAY0_EN
         check("order_bay", order[i], 0);
`else
         check("order_bay", order[i], i % N);
`endif
         check("order_pulses", pulses[i], SL);
      end
      do_reset();
      req = 4'b0011;
      repeat (5) @(posedge clk);
      #1 full = 4'b0001;
      @(negedge clk);
      check("full_no_pulse", int'(inc), 0);
      check("full_grant_held", int'(grant), 1);
      @(posedge clk); @(negedge clk);
      check("full_arb_gap", int'(grant), 0);
      @(posedge clk); @(negedge clk);
      check("full_next_owner", int'(grant), 2);
      bad = 0;
      repeat (40) begin @(negedge clk); if (grant[0]) bad++; end
      check("full_bay0_never", bad, 0);
      do_reset();
      req = 4'b1100;
      waited = 0;
      while (grant != 4'b0100 && waited < 20) begin @(negedge clk); waited++; end
      check("wait_bay2", int'(grant), 4);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("rst_grant", int'(grant), 0);
      check("rst_inc", int'(inc), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk); #1 rst_n = 1'b1; req = 4'b1111;
      waited = 0;
      while (grant == 0 && waited < 20) begin @(negedge clk); waited++; end
      check("rst_first_grant", int'(grant), 1);
      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #1;
         if (!rst_n) rst_n = 1'b1;
         if ($urandom_range(0, 9) == 0) req = N'($urandom);
         if ($urandom_range(0, 11) == 0) full[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 29) == 0) full = '0;
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
